cdc_bus_tx_arbiter: RTL and testbench

Source-domain controller that shares one bus-synchronizer channel (level enable plus data bus) between NUM_REQ requesters. It arbitrates round-robin and latches the winner's data. It then drives the data and the enable into the synchronizer using a 4-phase handshake, closed by an acknowledge level that the destination domain returns. A timeout prevents a lost acknowledge from hanging the channel.

---
 rtl/cdc_bus_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cdc_bus_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_bus_tx_arbiter.sv
// Round-robin arbiter that shares one level-enable bus-synchronizer channel
// between NUM_REQ requesters, using a 4-phase handshake closed by a synchronized ack.
module cdc_bus_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    input  logic                         ack_async,
    output logic [NUM_REQ-1:0]           grant,
    output logic [BUS_WIDTH-1:0]         tx_bus,
    output logic                         tx_enable,
    output logic [$clog2(NUM_REQ)-1:0]   tx_src,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ASSERT,
        ST_WAIT_LOW
    } state_t;

    state_t                          state_q, state_d;
    logic [SRC_W-1:0]                ptr_q, ptr_d;
    logic [NUM_REQ-1:0]              grant_q, grant_d;
    logic [BUS_WIDTH-1:0]            tx_bus_q, tx_bus_d;
    logic                            tx_enable_q, tx_enable_d;
    logic [SRC_W-1:0]                tx_src_q, tx_src_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic [TO_WIDTH-1:0]             cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]           ack_sync_q, ack_sync_d;
    logic                            ack_sync;

    logic [NUM_REQ-1:0][BUS_WIDTH-1:0] req_data_a;
    logic                              win_found;
    logic [SRC_W-1:0]                  win_idx;
    logic [SRC_W-1:0]                  cand;

    assign req_data_a = req_data;

    assign ack_sync_d = {ack_sync_q[NUM_STAGES-2:0], ack_async};
    assign ack_sync   = ack_sync_q[NUM_STAGES-1];

    // Scan upward from the slot after the last winner, wrapping once around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = SRC_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = '0;
        tx_bus_d    = tx_bus_q;
        tx_src_d    = tx_src_q;
        tx_enable_d = tx_enable_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                tx_enable_d = 1'b0;
                if (win_found) begin
                    grant_d[win_idx] = 1'b1;
                    tx_bus_d         = req_data_a[win_idx];
                    tx_src_d         = win_idx;
                    ptr_d            = win_idx;
                    state_d          = ST_SETUP;
                end
            end
            // Data has been stable for a full cycle before the enable rises.
            ST_SETUP: begin
                tx_enable_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_ASSERT;
            end
            // Ack takes precedence over a timeout landing on the same cycle.
            ST_ASSERT: begin
                cnt_d = cnt_q + TO_WIDTH'(1);
                if (ack_sync) begin
                    tx_enable_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_WAIT_LOW;
                end else if (cnt_q == TO_WIDTH'(TIMEOUT - 1)) begin
                    tx_enable_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                tx_enable_d = 1'b0;
                if (!ack_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_enable_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            ptr_q       <= SRC_W'(NUM_REQ - 1);
            grant_q     <= '0;
            tx_bus_q    <= '0;
            tx_enable_q <= 1'b0;
            tx_src_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            ack_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            tx_bus_q    <= tx_bus_d;
            tx_enable_q <= tx_enable_d;
            tx_src_q    <= tx_src_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            ack_sync_q  <= ack_sync_d;
        end
    end

    assign grant     = grant_q;
    assign tx_bus    = tx_bus_q;
    assign tx_enable = tx_enable_q;
    assign tx_src    = tx_src_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cdc_bus_tx_arbiter.sv
// Scoreboard bench for cdc_bus_tx_arbiter: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_cdc_bus_tx_arbiter;

    localparam int NR = 2;
    localparam int BW = 8;
    localparam int NS = 2;
    localparam int TO = 8;
    localparam int TW = 8;
    localparam int SW = $clog2(NR);

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [NR-1:0]     req;
    logic [NR*BW-1:0]  req_data = '0;
    logic              ack_async;
    logic [NR-1:0]     grant;
    logic [BW-1:0]     tx_bus;
    logic              tx_enable;
    logic [SW-1:0]     tx_src;
    logic              busy;
    logic              done;
    logic              err;

    cdc_bus_tx_arbiter #(
        .NUM_REQ(NR), .BUS_WIDTH(BW), .NUM_STAGES(NS), .TIMEOUT(TO), .TO_WIDTH(TW)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .ack_async(ack_async),
        .grant(grant), .tx_bus(tx_bus), .tx_enable(tx_enable), .tx_src(tx_src),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NR-1:0] g;
        logic [SW-1:0] src;
        logic [BW-1:0] bus;
    } gexp_t;

    gexp_t       exp_g[$];
    logic [1:0]  exp_e[$];
    int          errors = 0;
    int          checks = 0;
    int          issued[NR] = '{default: 0};
    int          served[NR] = '{default: 0};
    int          rise_at = 3;
    int          fall_after = 3;
    logic [BW-1:0] cur_bus = '0;
    logic [NR-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic push_g(input int i, input logic [BW-1:0] d);
        gexp_t e;
        e.g    = '0;
        e.g[i] = 1'b1;
        e.src  = SW'(i);
        e.bus  = d;
        exp_g.push_back(e);
    endtask

    task automatic push_e(input logic d, input logic e);
        exp_e.push_back({d, e});
    endtask

    task automatic issue(input int i);
        issued[i]++;
    endtask

    task automatic measure_en(input string name, input int want);
        int n = 0;
        int t = 0;
        while (!tx_enable && t < 50) begin
            @(negedge CLK);
            t++;
        end
        while (tx_enable && n < 100) begin
            n++;
            @(negedge CLK);
        end
        check(name, n, want);
    endtask

    task automatic wait_idle(input string name);
        int  t = 0;
        logic ok;
        ok = 1'b0;
        while (!ok && t < 500) begin
            @(negedge CLK);
            t++;
            ok = (busy == 1'b0) && (req == '0) && (exp_g.size() == 0) && (exp_e.size() == 0);
        end
        check(name, ok, 1);
    endtask

    // Requesters hold req until they have been granted as often as issued.
    initial begin
        req = '0;
        forever begin
            @(posedge CLK);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (grant[i]) served[i]++;
                req[i] = (issued[i] > served[i]);
            end
        end
    end

    // Destination model: ack rises after rise_at enabled cycles (0 = never),
    // falls fall_after cycles once the enable has dropped.
    initial begin
        int en_cnt;
        int lo_cnt;
        ack_async = 1'b0;
        en_cnt = 0;
        lo_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                ack_async = 1'b0;
                en_cnt = 0;
                lo_cnt = 0;
            end else if (tx_enable) begin
                en_cnt++;
                if (en_cnt == rise_at) ack_async = 1'b1;
            end else begin
                en_cnt = 0;
                if (ack_async) begin
                    lo_cnt++;
                    if (lo_cnt >= fall_after) begin
                        ack_async = 1'b0;
                        lo_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        gexp_t e;
        forever begin
            @(negedge CLK);
            if (prev_grant != '0) check("enable_after_grant", tx_enable, 1);
            if (grant != '0) begin
                if (exp_g.size() == 0) begin
                    check("unexpected_grant", grant, 0);
                end else begin
                    e = exp_g.pop_front();
                    check("grant", grant, e.g);
                    check("tx_src", tx_src, e.src);
                    check("tx_bus_at_grant", tx_bus, e.bus);
                    cur_bus = e.bus;
                end
            end
            if (tx_enable) begin
                check("tx_bus_stable", tx_bus, cur_bus);
                check("busy_when_enabled", busy, 1);
            end
            if (done || err) begin
                check("done_err_exclusive", done && err, 0);
                if (exp_e.size() == 0) check("unexpected_end", {done, err}, 0);
                else check("end_kind", {done, err}, exp_e.pop_front());
            end
            prev_grant = grant;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int cyc;
        int fall_cyc;
        logic got;

        repeat (3) @(negedge CLK);
        check("reset_outputs", {grant, tx_bus, tx_enable, tx_src, busy, done, err}, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("idle_after_reset", {grant, tx_enable, busy, done, err}, 0);

        // Contention: requester 0 first after reset, then alternate.
        req_data = {8'h22, 8'h11};
        push_g(0, 8'h11); push_e(1, 0);
        push_g(1, 8'h22); push_e(1, 0);
        push_g(0, 8'h11); push_e(1, 0);
        push_g(1, 8'h22); push_e(1, 0);
        issue(0); issue(0); issue(1); issue(1);
        wait_idle("contention_idle");

        // Single transfer, ack 3 cycles after enable -> enable high 5 cycles.
        req_data[7:0] = 8'hA5;
        push_g(0, 8'hA5); push_e(1, 0);
        issue(0);
        measure_en("single_enable_len", 5);
        wait_idle("single_idle");

        // Timeout: no ack at all.
        rise_at = 0;
        req_data[15:8] = 8'h3C;
        push_g(1, 8'h3C); push_e(0, 1);
        issue(1);
        measure_en("timeout_enable_len", TO);
        wait_idle("timeout_idle");

        // Normal service after a timeout.
        rise_at = 3;
        req_data[7:0] = 8'h5A;
        push_g(0, 8'h5A); push_e(1, 0);
        issue(0);
        measure_en("post_timeout_enable_len", 5);
        wait_idle("post_timeout_idle");

        // ack_sync reaches 1 exactly on the last ASSERT cycle: ack wins.
        rise_at = 6;
        req_data[15:8] = 8'h96;
        push_g(1, 8'h96); push_e(1, 0);
        issue(1);
        measure_en("coincide_enable_len", TO);
        wait_idle("coincide_idle");

        // One cycle later than that: timeout wins.
        rise_at = 7;
        req_data[7:0] = 8'h69;
        push_g(0, 8'h69); push_e(0, 1);
        issue(0);
        measure_en("late_ack_enable_len", TO);
        wait_idle("late_ack_idle");

        // Asynchronous reset while the enable is high.
        rise_at = 0;
        req_data[7:0] = 8'hC3;
        push_g(0, 8'hC3);
        issue(0);
        t = 0;
        while (!tx_enable && t < 50) begin
            @(negedge CLK);
            t++;
        end
        @(negedge CLK);
        check("enable_before_reset", tx_enable, 1);
        #1;
        RST = 1'b0;
        #1;
        check("reset_async", {tx_enable, busy, tx_bus, tx_src, grant}, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;

        // After reset requester 0 wins first; stale ack holds off the second grant.
        rise_at = 3;
        fall_after = 20;
        req_data = {8'h1E, 8'hE1};
        push_g(0, 8'hE1); push_e(1, 0);
        push_g(1, 8'h1E); push_e(1, 0);
        issue(0); issue(1);
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!done && t < 100);
        check("stale_first_done", done, 1);
        cyc = 0;
        fall_cyc = -1;
        got = 1'b0;
        while (cyc < 100) begin
            @(negedge CLK);
            #1;
            cyc++;
            if (grant != '0) begin
                got = 1'b1;
                break;
            end
            if (!ack_async && fall_cyc < 0) fall_cyc = cyc;
        end
        check("stale_grant_seen", got, 1);
        check("stale_grant_gap", cyc - fall_cyc, 4);
        fall_after = 3;
        wait_idle("stale_idle");

        check("grant_queue_drained", exp_g.size(), 0);
        check("end_queue_drained", exp_e.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
